// File: rtl/visitor_streamer_if.sv
// ---------------------------------------------------------------------------
// visitor_streamer_if
//   Output stream bundle of visitor_streamer: one visitor per beat,
//   valid/ready handshake, visitor index and last-beat marker alongside the
//   attribute word.
//
//   Signals (named from the streamer's point of view):
//     o_valid  beat valid
//     i_ready  downstream accepts beat
//     o_data   NUM_ATTR*DATA_W attribute word, attr k at [k*DATA_W +: DATA_W]
//     o_index  visitor index of the beat
//     o_last   beat carries visitor N-1
//
//   Modports: master = streamer side, slave = neighbourhood pipeline side.
// ---------------------------------------------------------------------------
interface visitor_streamer_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int NUM_ATTR = 3
) ();
    logic                       o_valid;
    logic                       i_ready;
    logic [NUM_ATTR*DATA_W-1:0] o_data;
    logic [ADDR_W-1:0]          o_index;
    logic                       o_last;

    modport master (
        output o_valid,
        output o_data,
        output o_index,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid,
        input  o_data,
        input  o_index,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/visitor_streamer.sv
// ---------------------------------------------------------------------------
// visitor_streamer
//   Holds per-body attributes written by the HPS in a simple dual-port RAM
//   (one RAM per attribute) and, on a start pulse, streams visitors 0..N-1
//   to the neighbourhood pipeline at one visitor per cycle. The RAM read
//   latency is hidden by a two-entry output buffer built from the RAM read
//   register plus one skid register.
//
//   Ports:
//     i_clk, i_rst      clock, synchronous active-high reset
//     i_wr_en           HPS write strobe
//     i_wr_index        HPS write address
//     i_wr_data         attribute word, attr k at [k*DATA_W +: DATA_W]
//     i_num_visitors    body count, sampled when a start is accepted
//     i_start           start one pass (pulse, ignored while busy)
//     stream            output beat bundle (visitor_streamer_if.master)
//     o_busy            pass in progress
//     o_done            one-cycle pulse after the last beat is accepted
//     o_wr_err          sticky write-during-pass flag
//
//   Build option:
//     VS_WRITE_LOCK_EN  when defined, HPS writes while busy are dropped and
//                       set o_wr_err (cleared by reset or the next accepted
//                       start). When undefined, such writes reach the RAM and
//                       o_wr_err is tied low.
// ---------------------------------------------------------------------------
module visitor_streamer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4096,
    parameter int NUM_ATTR = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [ADDR_W-1:0]          i_wr_index,
    input  logic [NUM_ATTR*DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W:0]            i_num_visitors,
    input  logic                       i_start,
    visitor_streamer_if.master         stream,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_wr_err
);
    localparam int              LP_W     = NUM_ATTR * DATA_W;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    // control state
    state_t          r_state;
    state_t          w_state_next;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] w_rd_ptr_next;
    logic [ADDR_W:0] w_rd_ptr_inc;
    logic [ADDR_W:0] r_num;
    logic [ADDR_W:0] w_num_next;
    logic [ADDR_W:0] w_num_clamped;
    logic            r_done;
    logic            w_done_next;
    logic            w_start_ok;
    logic            w_rd_issue;
    logic            w_issue_last;
    logic            w_busy;

    // output buffer: RAM read register (newer) + skid register (older)
    logic [LP_W-1:0]   w_rd_data;
    logic [ADDR_W-1:0] r_rd_idx;
    logic              r_rd_last;
    logic              r_rd_vld;
    logic [LP_W-1:0]   r_sk_data;
    logic [ADDR_W-1:0] r_sk_idx;
    logic              r_sk_last;
    logic              r_sk_vld;
    logic [1:0]        w_occ;

    // head of buffer
    logic              w_valid;
    logic [LP_W-1:0]   w_head_data;
    logic [ADDR_W-1:0] w_head_idx;
    logic              w_head_last;
    logic              w_pop;

    // write port
    logic              w_wr_in_range;
    logic              w_wr_allow;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_busy        = (r_state != S_IDLE);
    assign w_num_clamped = (i_num_visitors > LP_DEPTH) ? LP_DEPTH : i_num_visitors;
    assign w_rd_ptr_inc  = r_rd_ptr + 1'b1;
    assign w_issue_last  = (w_rd_ptr_inc == r_num);
    assign w_rd_addr     = r_rd_ptr[ADDR_W-1:0];
    assign w_wr_in_range = ({1'b0, i_wr_index} < LP_DEPTH);

    // -----------------------------------------------------------------------
    // Write lock option
    // -----------------------------------------------------------------------
`ifdef VS_WRITE_LOCK_EN
    logic r_wr_err;

    assign w_wr_allow = i_wr_en & w_wr_in_range & ~w_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_err <= 1'b0;
        end else if (w_start_ok) begin
            r_wr_err <= 1'b0;
        end else if (i_wr_en && w_busy) begin
            r_wr_err <= 1'b1;
        end
    end

    assign o_wr_err = r_wr_err;
`else
    assign w_wr_allow = i_wr_en & w_wr_in_range;
    assign o_wr_err   = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Attribute RAMs, one per attribute. The read register only loads when a
    // read is issued, so it also serves as the newer buffer entry. Both
    // processes sample mem with non-blocking semantics, which gives
    // read-before-write on a same-address collision.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ATTR; gi++) begin : g_attr
            logic [DATA_W-1:0] mem [0:DEPTH-1];
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge i_clk) begin
                if (w_wr_allow) begin
                    mem[i_wr_index] <= i_wr_data[gi*DATA_W +: DATA_W];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_q <= '0;
                end else if (w_rd_issue) begin
                    r_q <= mem[w_rd_addr];
                end
            end

            assign w_rd_data[gi*DATA_W +: DATA_W] = r_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Buffer head and handshake
    // -----------------------------------------------------------------------
    assign w_occ       = {1'b0, r_sk_vld} + {1'b0, r_rd_vld};
    assign w_valid     = r_sk_vld | r_rd_vld;
    assign w_head_data = r_sk_vld ? r_sk_data : w_rd_data;
    assign w_head_idx  = r_sk_vld ? r_sk_idx  : r_rd_idx;
    assign w_head_last = r_sk_vld ? r_sk_last : r_rd_last;
    assign w_pop       = w_valid & stream.i_ready;

    // Outputs read as zero whenever no beat is presented.
    assign stream.o_valid = w_valid;
    assign stream.o_data  = w_valid ? w_head_data : '0;
    assign stream.o_index = w_valid ? w_head_idx  : '0;
    assign stream.o_last  = w_valid & w_head_last;
    assign o_busy         = w_busy;
    assign o_done         = r_done;

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_rd_ptr_next = r_rd_ptr;
        w_num_next    = r_num;
        w_done_next   = 1'b0;
        w_rd_issue    = 1'b0;
        w_start_ok    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_ok = 1'b1;
                    if (w_num_clamped == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next  = S_STREAM;
                        w_rd_ptr_next = '0;
                        w_num_next    = w_num_clamped;
                    end
                end
            end

            S_STREAM: begin
                // The read register counts as occupancy, so with one-cycle
                // latency there is never an older read still outstanding.
                if (w_occ < 2'd2) begin
                    w_rd_issue    = 1'b1;
                    w_rd_ptr_next = w_rd_ptr_inc;
                    if (w_issue_last) begin
                        w_state_next = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (w_pop && w_head_last) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_rd_ptr <= '0;
            r_num    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_num    <= w_num_next;
            r_done   <= w_done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Buffer bookkeeping. The skid only ever holds the older beat: when a new
    // read overwrites a read register that was not popped, its beat moves to
    // the skid first.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_idx  <= '0;
            r_rd_last <= 1'b0;
            r_sk_vld  <= 1'b0;
            r_sk_data <= '0;
            r_sk_idx  <= '0;
            r_sk_last <= 1'b0;
        end else begin
            if (w_rd_issue) begin
                r_rd_vld  <= 1'b1;
                r_rd_idx  <= w_rd_addr;
                r_rd_last <= w_issue_last;
            end else if (w_pop && !r_sk_vld) begin
                r_rd_vld <= 1'b0;
            end

            if (r_sk_vld) begin
                if (w_pop) begin
                    r_sk_vld <= 1'b0;
                end
            end else if (w_rd_issue && r_rd_vld && !w_pop) begin
                r_sk_vld  <= 1'b1;
                r_sk_data <= w_rd_data;
                r_sk_idx  <= r_rd_idx;
                r_sk_last <= r_rd_last;
            end
        end
    end

endmodule

// File: tb/tb_visitor_streamer.sv
// ---------------------------------------------------------------------------
// tb_visitor_streamer
//   Directed bench for visitor_streamer (default parameters). Expected
//   attribute words come from a small model array filled with the values
//   the bench writes; beat timing is checked against hand-computed cycles.
//   Follows the VS_WRITE_LOCK_EN build option for the write-during-pass case.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_visitor_streamer;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 12;
    localparam int DEPTH    = 4096;
    localparam int NUM_ATTR = 3;
    localparam int W        = DATA_W * NUM_ATTR;

    logic              clk;
    logic              rst;
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_index;
    logic [W-1:0]      i_wr_data;
    logic [ADDR_W:0]   i_num_visitors;
    logic              i_start;
    logic              o_busy;
    logic              o_done;
    logic              o_wr_err;

    int n_checks;
    int n_errors;

    logic [W-1:0] model [0:7];

    visitor_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ATTR(NUM_ATTR)) sif ();

    visitor_streamer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NUM_ATTR (NUM_ATTR)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (i_wr_en),
        .i_wr_index     (i_wr_index),
        .i_wr_data      (i_wr_data),
        .i_num_visitors (i_num_visitors),
        .i_start        (i_start),
        .stream         (sif),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_wr_err       (o_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] attr_word(input int k);
        return {32'(1000 + k), 32'(100 + k), 32'(k)};
    endfunction

    task automatic write_word(input int idx, input logic [W-1:0] data);
        i_wr_en    = 1'b1;
        i_wr_index = ADDR_W'(idx);
        i_wr_data  = data;
        tick();
        i_wr_en    = 1'b0;
    endtask

    // One full pass. Cycle c counts from the start pulse (c=1 is t+1).
    // Ready is dropped for beats-relative cycles stall_lo..stall_hi after the
    // first valid. restart_at / wr_at inject a start or a write into index 3
    // at that cycle (0 = never).
    task automatic run_pass(input int n_num, input int n_exp, input int exp_done,
                            input int stall_lo, input int stall_hi, input int chk_n,
                            input int restart_at, input int wr_at, input logic [W-1:0] wr_val);
        int           beats;
        int           first_v;
        bit           rdy;
        bit           held;
        bit           done_seen;
        logic [W-1:0] held_d;
        logic [ADDR_W-1:0] held_i;
        beats     = 0;
        first_v   = -1;
        held      = 1'b0;
        done_seen = 1'b0;
        held_d    = '0;
        held_i    = '0;

        i_num_visitors = (ADDR_W + 1)'(n_num);
        i_start        = 1'b1;
        sif.i_ready    = 1'b1;
        tick();
        i_start = 1'b0;

        for (int c = 1; c <= exp_done + 4; c++) begin
            i_start = (c == restart_at);
            if (c == restart_at) i_num_visitors = (ADDR_W + 1)'(1);
            i_wr_en    = (c == wr_at);
            i_wr_index = ADDR_W'(3);
            i_wr_data  = wr_val;
`ifndef VS_WRITE_LOCK_EN
            if (c == wr_at) model[3] = wr_val;
`endif
            if (c == 1) begin
                check_value("busy_t1", 128'(o_busy), 128'(1));
                check_value("valid_t1", 128'(sif.o_valid), 128'(0));
                check_value("wr_err_t1", 128'(o_wr_err), 128'(0));
            end
            if (sif.o_valid && first_v < 0) begin
                first_v = c;
                check_value("first_valid_cycle", 128'(c), 128'(2));
            end
            rdy = !(first_v >= 0 && (c - first_v) >= stall_lo && (c - first_v) <= stall_hi);
            sif.i_ready = rdy;
            if (held) begin
                check_value("hold_data", 128'(sif.o_data), 128'(held_d));
                check_value("hold_index", 128'(sif.o_index), 128'(held_i));
                check_value("hold_valid", 128'(sif.o_valid), 128'(1));
            end
            if (o_done) begin
                check_value("done_with_valid", 128'(sif.o_valid), 128'(0));
                check_value("done_cycle", 128'(c), 128'(exp_done));
                check_value("beat_count", 128'(beats), 128'(n_exp));
                check_value("busy_at_done", 128'(o_busy), 128'(0));
                done_seen = 1'b1;
                break;
            end
            if (sif.o_valid && rdy) begin
                check_value("beat_index", 128'(sif.o_index), 128'(beats));
                check_value("beat_last", 128'(sif.o_last), 128'(beats == n_exp - 1));
                if (beats < chk_n) check_value("beat_data", 128'(sif.o_data), 128'(model[beats]));
                beats++;
            end
            held   = sif.o_valid && !rdy;
            held_d = sif.o_data;
            held_i = sif.o_index;
            tick();
        end
        i_start     = 1'b0;
        i_wr_en     = 1'b0;
        sif.i_ready = 1'b1;
        check_value("done_seen", 128'(done_seen), 128'(1));
        $display("pass N=%0d beats=%0d first_valid=t+%0d", n_num, beats, first_v);
        tick();
        check_value("done_pulse_end", 128'(o_done), 128'(0));
        check_value("idle_no_valid", 128'(sif.o_valid), 128'(0));
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        i_wr_en        = 1'b0;
        i_wr_index     = '0;
        i_wr_data      = '0;
        i_num_visitors = '0;
        i_start        = 1'b0;
        sif.i_ready    = 1'b1;
        for (int k = 0; k < 8; k++) model[k] = '0;

        // reset state
        tick(); tick(); tick();
        rst = 1'b0;
        check_value("rst_valid", 128'(sif.o_valid), 128'(0));
        check_value("rst_data", 128'(sif.o_data), 128'(0));
        check_value("rst_index", 128'(sif.o_index), 128'(0));
        check_value("rst_last", 128'(sif.o_last), 128'(0));
        check_value("rst_busy", 128'(o_busy), 128'(0));
        check_value("rst_done", 128'(o_done), 128'(0));
        check_value("rst_wr_err", 128'(o_wr_err), 128'(0));

        // load bodies 0..4
        for (int k = 0; k < 5; k++) begin
            model[k] = attr_word(k);
            write_word(k, model[k]);
        end

        // N=5, ready held high: last beat t+6, done t+7
        run_pass(5, 5, 7, 1000, -1, 5, 0, 0, '0);

        // N=5, ready low 3..6 cycles after first valid: done t+11
        run_pass(5, 5, 11, 3, 6, 5, 0, 0, '0);

        // N=0: done at t+1, nothing streamed
        i_num_visitors = '0;
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
        check_value("n0_done", 128'(o_done), 128'(1));
        check_value("n0_valid", 128'(sif.o_valid), 128'(0));
        check_value("n0_busy", 128'(o_busy), 128'(0));
        tick();
        check_value("n0_done_pulse", 128'(o_done), 128'(0));
        check_value("n0_valid_after", 128'(sif.o_valid), 128'(0));
        $display("pass N=0 done pulse only");

        // N=5000 clamps to 4096 beats, last index 4095, done t+4098
        run_pass(5000, 4096, 4098, 1000, -1, 5, 0, 0, '0);

        // start during pass (and a new count) is ignored
        run_pass(5, 5, 7, 1000, -1, 5, 2, 0, '0);
        tick();
        check_value("restart_not_queued", 128'(sif.o_valid), 128'(0));
        check_value("restart_not_busy", 128'(o_busy), 128'(0));

        // reset while beat 2 is presented
        i_num_visitors = (ADDR_W + 1)'(5);
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick(); tick();
        check_value("pre_rst_index", 128'(sif.o_index), 128'(2));
        check_value("pre_rst_valid", 128'(sif.o_valid), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("midrst_valid", 128'(sif.o_valid), 128'(0));
        check_value("midrst_data", 128'(sif.o_data), 128'(0));
        check_value("midrst_index", 128'(sif.o_index), 128'(0));
        check_value("midrst_last", 128'(sif.o_last), 128'(0));
        check_value("midrst_busy", 128'(o_busy), 128'(0));
        check_value("midrst_done", 128'(o_done), 128'(0));
        tick();
        check_value("midrst_no_done", 128'(o_done), 128'(0));
        $display("reset mid-pass at beat 2");

        // fresh pass after reset streams from index 0 with RAM retained
        run_pass(5, 5, 7, 1000, -1, 5, 0, 0, '0);

        // write to index 3 during a pass
        run_pass(5, 5, 7, 1000, -1, 5, 0, 2, {32'hCAFE_0003, 32'hBEEF_0003, 32'hF00D_0003});
`ifdef VS_WRITE_LOCK_EN
        check_value("wr_err_after_pass", 128'(o_wr_err), 128'(1));
`else
        check_value("wr_err_after_pass", 128'(o_wr_err), 128'(0));
`endif
        // next pass shows the RAM state left by that write; wr_err clears at start
        run_pass(5, 5, 7, 1000, -1, 5, 0, 0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
